// File: rtl/kgp_pkg.sv
// ---------------------------------------------------------------------------
// kgp_pkg
// Shared definitions for the KGP-RISC fetch path:
//   - redirect kind encodings carried on redirect_kind
//   - fetch sequencer FSM state encoding
//   - default program counter loaded on reset
// ---------------------------------------------------------------------------
package kgp_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REDIR_BR   = 2'b00,  // cur_pc-relative branch
    REDIR_JMP  = 2'b01,  // absolute jump
    REDIR_CALL = 2'b10,  // absolute call, produces a link address
    REDIR_RET  = 2'b11   // return
  } redir_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_HOLD   = 2'b10,
    ST_HALTED = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/kgp_ras.sv
// ---------------------------------------------------------------------------
// kgp_ras
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty is ignored. pop_data always shows the top entry.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   push       write push_data on top of the stack
//   push_data  address to push
//   pop        remove the top entry
//   pop_data   current top entry (valid when !empty)
//   empty      no entries held
//   full       DEPTH entries held
// ---------------------------------------------------------------------------
module kgp_ras #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;   // next slot to write
  logic [PTR_W-1:0]  top_ptr;  // most recently written slot
  logic [CNT_W-1:0]  count;

  assign top_ptr  = (wr_ptr == '0) ? LAST : wr_ptr - PTR_W'(1);
  assign pop_data = mem[top_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (push) begin
      // The write pointer wraps over the oldest entry once full; count saturates.
      mem[wr_ptr] <= push_data;
      wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/kgp_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// kgp_fetch_sequencer
// Owns the program counter, issues instruction-memory requests and hands
// fetched words to decode over a valid/ready handshake. Applies redirects
// (branch, jump, call, return) from execute relative to cur_pc, the PC of
// the last instruction decode accepted.
//
// Build option: define KGP_RAS_EN to add a RAS_DEPTH-entry return-address
// stack (kgp_ras). Without it, returns go to redirect_target.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   imem_req/imem_addr        fetch request and address (address == pc)
//   imem_ack/imem_rdata       fetch completion and instruction word
//   instr_valid/instr_ready   handshake to decode
//   instr_data/instr_pc       registered instruction and its PC
//   redirect_valid/kind/target  one-cycle redirect from execute
//   link_we/link_addr         link register write for calls
//   halt/halted               stop after the current handoff / stopped
// ---------------------------------------------------------------------------
module kgp_fetch_sequencer
  import kgp_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_kind,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  input  logic              halt,
  output logic              halted
);

  if (RAS_DEPTH < 1) begin : g_bad_ras_depth
    $error("kgp_fetch_sequencer: RAS_DEPTH must be at least 1");
  end

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] cur_pc;
  logic [ADDR_W-1:0] link_next;
  logic [ADDR_W-1:0] redir_raw;
  logic [ADDR_W-1:0] redir_pc;
  logic              squash;      // the outstanding request belongs to an abandoned path
  logic              redir_take;
  logic              fetch_hit;
  logic              accept;
  logic              is_call;

  assign redir_take = redirect_valid && (state != ST_HALTED);
  // A redirect in the same cycle as an ack discards that ack.
  assign fetch_hit  = (state == ST_FETCH) && imem_ack && !squash && !redirect_valid;
  // A redirect in the same cycle as ready voids the handshake.
  assign accept     = (state == ST_HOLD) && instr_ready && !redirect_valid;
  assign is_call    = redir_take && (redirect_kind == REDIR_CALL);
  assign link_next  = cur_pc + ADDR_W'(4);

`ifdef KGP_RAS_EN
  logic              ras_pop;
  logic              ras_empty;
  logic [ADDR_W-1:0] ras_top;

  kgp_ras #(
    .DEPTH  (RAS_DEPTH),
    .DATA_W (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (is_call),
    .push_data (link_next),
    .pop       (ras_pop),
    .pop_data  (ras_top),
    .empty     (ras_empty),
    .full      ()
  );
`endif

  always_comb begin
    redir_raw = redirect_target;
`ifdef KGP_RAS_EN
    ras_pop   = 1'b0;
`endif
    case (redirect_kind)
      REDIR_BR:  redir_raw = cur_pc + redirect_target;
      REDIR_RET: begin
`ifdef KGP_RAS_EN
        if (!ras_empty) begin
          redir_raw = ras_top;
          ras_pop   = redir_take;
        end
`endif
      end
      default:   redir_raw = redirect_target;
    endcase
    redir_pc = redir_raw & ~ADDR_W'(3);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_FETCH;
      ST_FETCH:  if (fetch_hit) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (redirect_valid)   state_nxt = ST_FETCH;
        else if (instr_ready) state_nxt = halt ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      cur_pc     <= RESET_PC;
      instr_pc   <= RESET_PC;
      instr_data <= '0;
      squash     <= 1'b0;
      link_we    <= 1'b0;
      link_addr  <= '0;
    end else begin
      link_we <= is_call;
      if (is_call) link_addr <= link_next;

      if (redir_take) begin
        pc <= redir_pc;
      end else if (accept) begin
        pc     <= instr_pc + ADDR_W'(4);
        cur_pc <= instr_pc;
      end

      if (fetch_hit) begin
        instr_data <= imem_rdata;
        instr_pc   <= pc;
      end

      // Redirect with no ack leaves the old request in flight: drop its ack
      // when it eventually arrives. Any ack clears the pending squash.
      if (state == ST_FETCH) squash <= redirect_valid ? !imem_ack : (squash && !imem_ack);
      else                   squash <= 1'b0;
    end
  end

  assign imem_req    = (state == ST_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == ST_HOLD);
  assign halted      = (state == ST_HALTED);

endmodule

// File: tb/tb_kgp_fetch_sequencer.sv
module tb_kgp_fetch_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;
`ifdef KGP_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        instr_valid;
  logic        ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        rv = 1'b0;
  logic [1:0]  kind = 2'b00;
  logic [31:0] tgt = '0;
  logic        link_we;
  logic [31:0] link_addr;
  logic        halt = 1'b0;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  kgp_fetch_sequencer #(
    .ADDR_W    (32),
    .RESET_PC  (RPC),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (ack),
    .imem_rdata      (rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .redirect_valid  (rv),
    .redirect_kind   (kind),
    .redirect_target (tgt),
    .link_we         (link_we),
    .link_addr       (link_addr),
    .halt            (halt),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (flag based, per-instruction view) ----
  logic [31:0] m_pc, m_cur, m_ipc, m_idata, m_link_addr;
  logic        m_link_we, m_started, m_has, m_halted, m_squash;
  logic [31:0] m_ras[$];

  function automatic logic m_req();
    return m_started && !m_has && !m_halted;
  endfunction

  function automatic logic m_valid();
    return m_has && !m_halted;
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_cur = RPC; m_ipc = RPC; m_idata = '0; m_link_addr = '0;
    m_link_we = 1'b0; m_started = 1'b0; m_has = 1'b0; m_halted = 1'b0; m_squash = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [31:0] t;
    logic        req_now, val_now;
    req_now   = m_req();
    val_now   = m_valid();
    m_link_we = 1'b0;
    if (rv && !m_halted) begin
      t = tgt;
      if (kind == 2'b00) t = m_cur + tgt;
      if (kind == 2'b11 && RAS_ON && m_ras.size() > 0) t = m_ras.pop_back();
      if (kind == 2'b10) begin
        m_link_we   = 1'b1;
        m_link_addr = m_cur + 32'd4;
        if (RAS_ON) begin
          m_ras.push_back(m_cur + 32'd4);
          if (m_ras.size() > int'(DEPTH)) void'(m_ras.pop_front());
        end
      end
      m_pc = t & 32'hFFFF_FFFC;
      // An unanswered request is abandoned; its late answer must be dropped.
      if (req_now) m_squash = !ack;
      m_has = 1'b0;
    end else if (req_now && ack) begin
      if (m_squash) m_squash = 1'b0;
      else begin
        m_idata = rdata; m_ipc = m_pc; m_has = 1'b1;
      end
    end else if (val_now && ready) begin
      m_cur = m_ipc; m_pc = m_ipc + 32'd4; m_has = 1'b0;
      if (halt) m_halted = 1'b1;
    end
    m_started = 1'b1;
  endtask

  // ---------------- checking helpers --------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("imem_req", imem_req, m_req());
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, m_valid());
    chk("instr_pc", instr_pc, m_ipc);
    chk("instr_data", instr_data, m_idata);
    chk("link_we", link_we, m_link_we);
    chk("link_addr", link_addr, m_link_addr);
    chk("halted", halted, m_halted);
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", instr_valid, 0);
    chk("rst_ipc", instr_pc, RPC);
    chk("rst_data", instr_data, 0);
    chk("rst_link_we", link_we, 0);
    chk("rst_link_addr", link_addr, 0);
    chk("rst_halted", halted, 0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Jump to a, then run until decode has accepted the instruction at a.
  task automatic goto_accept(input logic [31:0] a);
    int n = 0;
    rv = 1'b1; kind = 2'b01; tgt = a; ack = 1'b0; ready = 1'b0;
    step();
    rv = 1'b0; ack = 1'b1; ready = 1'b1;
    while (m_cur != a && n < 50) begin
      rdata = a ^ 32'hA5A5_0000;
      step();
      n++;
    end
    if (m_cur != a) begin
      n_checks++; n_fail++;
      $display("FAIL goto_accept_timeout: cur_pc %h never reached %h", m_cur, a);
    end
    ack = 1'b0; ready = 1'b0;
  endtask

  // ---------------- table for the streaming case --------------------------
  typedef struct {
    logic        ack;
    logic        ready;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] exp_ret;

    tbl[0] = '{1'b1, 1'b1, 32'hAAAA_AAAA, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h1111_0000, 1'b1, 32'h0,  1'b0, 32'h0,  32'h0};
    tbl[2] = '{1'b1, 1'b1, 32'hBBBB_BBBB, 1'b0, 32'h0,  1'b1, 32'h0,  32'h1111_0000};
    tbl[3] = '{1'b1, 1'b1, 32'h2222_0004, 1'b1, 32'h4,  1'b0, 32'h0,  32'h0};
    tbl[4] = '{1'b1, 1'b1, 32'hCCCC_CCCC, 1'b0, 32'h0,  1'b1, 32'h4,  32'h2222_0004};
    tbl[5] = '{1'b1, 1'b1, 32'h3333_0008, 1'b1, 32'h8,  1'b0, 32'h0,  32'h0};
    tbl[6] = '{1'b1, 1'b1, 32'hDDDD_DDDD, 1'b0, 32'h0,  1'b1, 32'h8,  32'h3333_0008};
    tbl[7] = '{1'b1, 1'b1, 32'h4444_000C, 1'b1, 32'hC,  1'b0, 32'h0,  32'h0};
    tbl[8] = '{1'b1, 1'b1, 32'hEEEE_EEEE, 1'b0, 32'h0,  1'b1, 32'hC,  32'h4444_000C};

    // Streaming with ack and ready tied high.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ack = tbl[i].ack; ready = tbl[i].ready; rdata = tbl[i].rdata;
      sample();
      chk("tbl_req", imem_req, tbl[i].e_req);
      chk("tbl_valid", instr_valid, tbl[i].e_valid);
      if (tbl[i].e_req) chk("tbl_addr", imem_addr, tbl[i].e_addr);
      if (tbl[i].e_valid) begin
        chk("tbl_pc", instr_pc, tbl[i].e_pc);
        chk("tbl_data", instr_data, tbl[i].e_data);
      end
      advance();
    end

    // Relative branch wrap, with ready in the same cycle (redirect wins).
    do_reset();
    goto_accept(32'h10);
    ack = 1'b1; ready = 1'b0; step();
    rv = 1'b1; kind = 2'b00; tgt = 32'hFFFF_FFF0; ready = 1'b1; ack = 1'b0; step();
    rv = 1'b0; ready = 1'b0;
    sample();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", imem_req, 1);
    chk("wrap_valid_drop", instr_valid, 0);
    advance();
    rv = 1'b1; kind = 2'b00; tgt = 32'h20; step();
    rv = 1'b0;
    sample();
    chk("cur_pc_kept", imem_addr, 32'h30);
    advance();

    // Jump to unaligned 0x103 in FETCH; the late ack is discarded.
    rv = 1'b1; kind = 2'b01; tgt = 32'h103; ack = 1'b0; step();
    rv = 1'b0;
    sample(); chk("late_addr", imem_addr, 32'h100); advance();
    ack = 1'b1; rdata = 32'hDEAD_DEAD; step();
    ack = 1'b0;
    sample();
    chk("late_dropped", instr_valid, 0);
    chk("late_req", imem_req, 1);
    chk("late_addr2", imem_addr, 32'h100);
    advance();
    ack = 1'b1; rdata = 32'hBEEF_BEEF; step();
    ack = 1'b0;
    sample();
    chk("late_valid", instr_valid, 1);
    chk("late_pc", instr_pc, 32'h100);
    chk("late_data", instr_data, 32'hBEEF_BEEF);
    advance();

    // Call then return.
    goto_accept(32'h40);
    rv = 1'b1; kind = 2'b10; tgt = 32'h200; step();
    rv = 1'b0;
    sample();
    chk("call_link_we", link_we, 1);
    chk("call_link_addr", link_addr, 32'h44);
    chk("call_addr", imem_addr, 32'h200);
    advance();
    sample(); chk("call_link_we_pulse", link_we, 0); advance();
    rv = 1'b1; kind = 2'b11; tgt = 32'h80; step();
    rv = 1'b0;
    exp_ret = RAS_ON ? 32'h44 : 32'h80;
    sample(); chk("ret_addr", imem_addr, exp_ret); advance();

    // Five calls, then five returns.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      goto_accept(32'h1000 + 32'h100 * i);
      rv = 1'b1; kind = 2'b10; tgt = 32'h3000; step();
      rv = 1'b0;
    end
    for (int j = 0; j < 5; j++) begin
      rv = 1'b1; kind = 2'b11; tgt = 32'h5000; step();
      rv = 1'b0;
      exp_ret = (RAS_ON && j < 4) ? (32'h1404 - 32'h100 * j) : 32'h5000;
      sample(); chk("ras_ret_addr", imem_addr, exp_ret); advance();
    end

    // Halt with ready in HOLD; redirects are ignored afterwards.
    do_reset();
    goto_accept(32'h20);
    ack = 1'b1; ready = 1'b0; step();
    ack = 1'b0; halt = 1'b1; ready = 1'b1; step();
    halt = 1'b0; ready = 1'b0; ack = 1'b1; rv = 1'b1; kind = 2'b01; tgt = 32'h300;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("halt_halted", halted, 1);
      chk("halt_req", imem_req, 0);
      chk("halt_valid", instr_valid, 0);
      advance();
    end
    rv = 1'b0;
    do_reset();
    sample(); chk("restart_idle_req", imem_req, 0); advance();
    sample();
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, RPC);
    advance();

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      ack   = 1'($urandom_range(0, 1));
      ready = ($urandom_range(0, 9) < 6);
      rv    = ($urandom_range(0, 7) == 0);
      kind  = 2'($urandom_range(0, 3));
      tgt   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
      halt  = ($urandom_range(0, 63) == 0);
      rdata = $urandom;
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
